sync_fifo_param: RTL

Parametrised single-clock FIFO. It is the next generation of the team's 16x8 FIFO, generalised in data width and depth, with a selectable read mode (registered or first-word-fall-through), occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is the standard buffer for UVM example DUTs and benches going forward.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: address-width helper,
// read-mode selectors and the occupancy-to-flag decode.
package fifo_pkg;

    localparam int RD_REG  = 0;
    localparam int RD_FWFT = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Kept purely a function of occupancy so async variants can reuse it on a synchronised count.
    function automatic fifo_flags_t decode_flags(input int cnt, input int depth,
                                                 input int af_thresh, input int ae_thresh);
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 0);
        f.almost_full  = (cnt >= af_thresh);
        f.almost_empty = (cnt <= ae_thresh);
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through
// read, occupancy count, almost flags and sticky overflow/underflow errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 2,
    parameter  int FWFT      = 0,
    localparam int AW        = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wa_s, ra_s;
    logic [DATA_W-1:0] mem_rdata_s;
    fifo_flags_t       flags_s;

    assign flags_s = decode_flags(32'(count_q), DEPTH, AF_THRESH, AE_THRESH);
    assign wa_s    = wr_en && !flags_s.full;
    assign ra_s    = rd_en && !flags_s.empty;

    // pointer, occupancy and sticky error next-state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wa_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (ra_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Wrap bits make the modular difference span 0..DEPTH exactly.
        count_d = wr_ptr_d - rd_ptr_d;
        if (wr_en && flags_s.full) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_en && flags_s.empty) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wa_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata_s)
    );

    generate
        if (FWFT == RD_FWFT) begin : g_fwft
            assign rd_data  = mem_rdata_s;
            assign rd_valid = !flags_s.empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            // registered read stage: capture head on accepted read, hold otherwise
            always_comb begin
                rd_valid_d = ra_s;
                if (ra_s) begin
                    rd_data_d = mem_rdata_s;
                end else begin
                    rd_data_d = rd_data_q;
                end
            end

            // read output registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = flags_s.full;
    assign empty        = flags_s.empty;
    assign almost_full  = flags_s.almost_full;
    assign almost_empty = flags_s.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
